alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/alu_shifter.sv | 33 +++
 rtl/alu_pipe.sv | 211 +++++++++++++++++++++
 tb/tb_alu_pipe.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the alu_pipe block:
//   - opcode_e   : 4-bit operation encoding, all 16 codes named
//   - flag_cls_e : which architectural flags an operation updates when its
//                  result is handed off
//   - flag_class : maps an opcode to its flag-update class
// ----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_XOR    = 4'h2,
        OP_RED    = 4'h3,
        OP_SLL    = 4'h4,
        OP_SRA    = 4'h5,
        OP_ROR    = 4'h6,
        OP_PADDSB = 4'h7,
        OP_ADDR0  = 4'h8,
        OP_ADDR1  = 4'h9,
        OP_RSV_A  = 4'hA,
        OP_RSV_B  = 4'hB,
        OP_RSV_C  = 4'hC,
        OP_RSV_D  = 4'hD,
        OP_RSV_E  = 4'hE,
        OP_RSV_F  = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        FCLS_NONE = 2'd0,   // flags untouched
        FCLS_Z    = 2'd1,   // zero flag only
        FCLS_NZV  = 2'd2    // negative, zero and overflow
    } flag_cls_e;

    function automatic flag_cls_e flag_class(input opcode_e op);
        flag_cls_e cls;
        cls = FCLS_NONE;
        case (op)
            OP_ADD, OP_SUB:                 cls = FCLS_NZV;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: cls = FCLS_Z;
            default:                        cls = FCLS_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// ----------------------------------------------------------------------------
// alu_shifter
// Purely combinational shift/rotate unit used by alu_pipe.
//   op  : opcode; OP_SLL shifts left, OP_SRA shifts right arithmetic,
//         OP_ROR rotates right; any other code passes a through
//   a   : operand to shift
//   amt : shift/rotate amount (0 passes a unchanged)
//   y   : result
// ----------------------------------------------------------------------------
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   amt,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = a;
        case (op)
            OP_SLL: y = a << amt;
            OP_SRA: y = $signed(a) >>> amt;
            // With amt = 0 the left term shifts by WIDTH and vanishes.
            OP_ROR: y = (a >> amt) | (a << (WIDTH - int'(amt)));
            default: y = a;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// ----------------------------------------------------------------------------
// alu_pipe
// Two-stage ALU with valid/ready handshakes on both sides.
//   S1 captures opcode and operands; S2 holds the computed result.
//   Architectural flags (N/Z/V) change only when a result is handed off.
//
// Ports
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid, in_ready   : input handshake
//   opcode               : operation select (see alu_pkg::opcode_e)
//   alu_in1, alu_in2     : operands
//   out_valid, out_ready : output handshake
//   alu_out, error       : result and unsupported-opcode flag
//   n_flag, z_flag, v_flag : architectural flags
//
// Configuration
//   ALU_PIPE_PADDSB_EN : when defined, opcode 0111 performs a per-nibble
//                        signed saturating add; otherwise it is an error op.
// ----------------------------------------------------------------------------
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] alu_in1,
    input  logic [WIDTH-1:0] alu_in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             error,
    output logic             n_flag,
    output logic             z_flag,
    output logic             v_flag
);

    // Returns {overflow, saturated result}.
    function automatic logic [WIDTH:0] sat_addsub(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             sub);
        logic signed [WIDTH:0] ax;
        logic signed [WIDTH:0] bx;
        logic signed [WIDTH:0] s;
        logic [WIDTH-1:0]      r;
        logic                  ovf;
        ax  = $signed({a[WIDTH-1], a});
        bx  = $signed({b[WIDTH-1], b});
        s   = sub ? (ax - bx) : (ax + bx);
        ovf = s[WIDTH] ^ s[WIDTH-1];
        if (!ovf)
            r = s[WIDTH-1:0];
        else if (s[WIDTH])
            r = {1'b1, {(WIDTH-1){1'b0}}};
        else
            r = {1'b0, {(WIDTH-1){1'b1}}};
        return {ovf, r};
    endfunction

    // Signed sum of every nibble of both operands. The magnitude is at most
    // 4*WIDTH, which always fits in WIDTH signed bits for WIDTH >= 8.
    function automatic logic [WIDTH-1:0] red_sum(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] acc;
        acc = '0;
        for (int i = 0; i < WIDTH/4; i++) begin
            acc = acc + $signed({{(WIDTH-4){a[4*i+3]}}, a[4*i +: 4]})
                      + $signed({{(WIDTH-4){b[4*i+3]}}, b[4*i +: 4]});
        end
        return acc;
    endfunction

`ifdef ALU_PIPE_PADDSB_EN
    function automatic logic [WIDTH-1:0] paddsb(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        logic signed [4:0] s;
        r = '0;
        for (int i = 0; i < WIDTH/4; i++) begin
            s = $signed({a[4*i+3], a[4*i +: 4]}) + $signed({b[4*i+3], b[4*i +: 4]});
            if (s[4] ^ s[3])
                r[4*i +: 4] = s[4] ? 4'h8 : 4'h7;
            else
                r[4*i +: 4] = s[3:0];
        end
        return r;
    endfunction
`endif

    logic             vld_p1;
    opcode_e          op_p1;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;

    logic             vld_p2;
    logic [WIDTH-1:0] res_p2;
    logic             err_p2;
    flag_cls_e        fcls_p2;
    logic             n_p2;
    logic             z_p2;
    logic             v_p2;

    logic             s1_adv;
    logic             take;
    logic [WIDTH-1:0] shift_y;
    logic [WIDTH-1:0] res_c;
    logic             err_c;
    logic             v_c;

    assign s1_adv   = !vld_p2 || out_ready;
    assign in_ready = !vld_p1 || s1_adv;
    assign take     = vld_p2 && out_ready;

    // ---- S1: operand capture ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_p1 <= 1'b0;
        else if (in_ready)
            vld_p1 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            op_p1 <= opcode_e'(opcode);
            a_p1  <= alu_in1;
            b_p1  <= alu_in2;
        end
    end

    alu_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .op  (op_p1),
        .a   (a_p1),
        .amt (b_p1[SHW-1:0]),
        .y   (shift_y)
    );

    always_comb begin
        res_c = '0;
        err_c = 1'b0;
        v_c   = 1'b0;
        case (op_p1)
            OP_ADD:                 {v_c, res_c} = sat_addsub(a_p1, b_p1, 1'b0);
            OP_SUB:                 {v_c, res_c} = sat_addsub(a_p1, b_p1, 1'b1);
            OP_XOR:                 res_c = a_p1 ^ b_p1;
            OP_RED:                 res_c = red_sum(a_p1, b_p1);
            OP_SLL, OP_SRA, OP_ROR: res_c = shift_y;
`ifdef ALU_PIPE_PADDSB_EN
            OP_PADDSB:              res_c = paddsb(a_p1, b_p1);
`endif
            OP_ADDR0, OP_ADDR1:     res_c = a_p1 + b_p1;
            default:                err_c = 1'b1;
        endcase
    end

    // ---- S2: result register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2 <= 1'b0;
            res_p2 <= '0;
            err_p2 <= 1'b0;
        end else if (s1_adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                res_p2 <= res_c;
                err_p2 <= err_c;
            end
        end
    end

    // Candidate flag values travel with the result and are committed only
    // when the consumer takes it.
    always_ff @(posedge clk) begin
        if (s1_adv && vld_p1) begin
            fcls_p2 <= flag_class(op_p1);
            n_p2    <= res_c[WIDTH-1];
            z_p2    <= (res_c == '0);
            v_p2    <= v_c;
        end
    end

    // ---- Output handshake: architectural flags ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_flag <= 1'b0;
            z_flag <= 1'b0;
            v_flag <= 1'b0;
        end else if (take) begin
            case (fcls_p2)
                FCLS_NZV: begin
                    n_flag <= n_p2;
                    z_flag <= z_p2;
                    v_flag <= v_p2;
                end
                FCLS_Z:  z_flag <= z_p2;
                default: ;
            endcase
        end
    end

    assign out_valid = vld_p2;
    assign alu_out   = res_p2;
    assign error     = err_p2;

endmodule

// File: tb/tb_alu_pipe.sv
// ----------------------------------------------------------------------------
// tb_alu_pipe
// Directed testbench for alu_pipe at WIDTH = 16. A table of single ops with
// hand-computed results and cumulative flag values, followed by a
// back-pressure sequence and a reset-with-full-pipeline sequence.
// Expectations for opcode 0111 follow ALU_PIPE_PADDSB_EN.
// ----------------------------------------------------------------------------
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   opcode;
    logic [W-1:0] alu_in1;
    logic [W-1:0] alu_in2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_out;
    logic         error;
    logic         n_flag;
    logic         z_flag;
    logic         v_flag;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .error     (error),
        .n_flag    (n_flag),
        .z_flag    (z_flag),
        .v_flag    (v_flag)
    );

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] out;
        logic        err;
        logic [2:0]  nzv;   // flags expected after the handshake
    } vec_t;

`ifdef ALU_PIPE_PADDSB_EN
    localparam logic [15:0] P1_OUT = 16'h7777;
    localparam logic [15:0] P2_OUT = 16'h8888;
    localparam logic        P_ERR  = 1'b0;
`else
    localparam logic [15:0] P1_OUT = 16'h0000;
    localparam logic [15:0] P2_OUT = 16'h0000;
    localparam logic        P_ERR  = 1'b1;
`endif

    vec_t vt [24];
    vec_t bp [4];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        opcode  = v.op;
        alu_in1 = v.a;
        alu_in2 = v.b;
    endtask

    // One op with out_ready high: accept, check 2-cycle latency, result,
    // flags held before the handshake and updated after it.
    task automatic run_vec(input int i, input logic [2:0] prev);
        @(negedge clk);
        drive(vt[i]);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk($sformatf("v%0d_early_valid", i), 32'(out_valid), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
        chk($sformatf("v%0d_out", i), 32'(alu_out), 32'(vt[i].out));
        chk($sformatf("v%0d_err", i), 32'(error), 32'(vt[i].err));
        chk($sformatf("v%0d_flags_pre", i), 32'({n_flag, z_flag, v_flag}), 32'(prev));
        @(negedge clk);
        chk($sformatf("v%0d_flags", i), 32'({n_flag, z_flag, v_flag}), 32'(vt[i].nzv));
        chk($sformatf("v%0d_drained", i), 32'(out_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [2:0] prev;
        int  in_i;
        int  out_i;
        bit  acc_pend;
        bit  flg_pend;
        logic [2:0] cur_flags;

        vt[0]  = '{OP_ADD,    16'h7FFF, 16'h0001, 16'h7FFF, 1'b0,  3'b001};
        vt[1]  = '{OP_RED,    16'h1111, 16'h1111, 16'h0008, 1'b0,  3'b001};
        vt[2]  = '{OP_RED,    16'hFFFF, 16'hFFFF, 16'hFFF8, 1'b0,  3'b001};
        vt[3]  = '{OP_PADDSB, 16'h7777, 16'h1111, P1_OUT,   P_ERR, 3'b001};
        vt[4]  = '{OP_PADDSB, 16'h8888, 16'h8888, P2_OUT,   P_ERR, 3'b001};
        vt[5]  = '{OP_SUB,    16'h0005, 16'h0005, 16'h0000, 1'b0,  3'b010};
        vt[6]  = '{OP_ADD,    16'h8000, 16'hFFFF, 16'h8000, 1'b0,  3'b101};
        vt[7]  = '{OP_XOR,    16'h00FF, 16'h00FF, 16'h0000, 1'b0,  3'b111};
        vt[8]  = '{OP_XOR,    16'hA5A5, 16'h0F0F, 16'hAAAA, 1'b0,  3'b101};
        vt[9]  = '{OP_ROR,    16'h0001, 16'h0001, 16'h8000, 1'b0,  3'b101};
        vt[10] = '{OP_SLL,    16'h8000, 16'h0001, 16'h0000, 1'b0,  3'b111};
        vt[11] = '{OP_SRA,    16'h8000, 16'h000F, 16'hFFFF, 1'b0,  3'b101};
        vt[12] = '{OP_SLL,    16'h1234, 16'h0000, 16'h1234, 1'b0,  3'b101};
        vt[13] = '{OP_ROR,    16'h1234, 16'h0004, 16'h4123, 1'b0,  3'b101};
        vt[14] = '{OP_SRA,    16'h4000, 16'h0002, 16'h1000, 1'b0,  3'b101};
        vt[15] = '{OP_SLL,    16'h0001, 16'h0014, 16'h0010, 1'b0,  3'b101};
        vt[16] = '{OP_SUB,    16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b0,  3'b001};
        vt[17] = '{OP_ADD,    16'h1234, 16'h1111, 16'h2345, 1'b0,  3'b000};
        vt[18] = '{OP_ADD,    16'h7FFF, 16'h0001, 16'h7FFF, 1'b0,  3'b001};
        vt[19] = '{OP_ADDR0,  16'hFFFF, 16'h0002, 16'h0001, 1'b0,  3'b001};
        vt[20] = '{OP_ADDR1,  16'h7FFF, 16'h0001, 16'h8000, 1'b0,  3'b001};
        vt[21] = '{OP_RSV_A,  16'h1234, 16'h5678, 16'h0000, 1'b1,  3'b001};
        vt[22] = '{OP_RSV_F,  16'h1234, 16'h5678, 16'h0000, 1'b1,  3'b001};
        vt[23] = '{OP_SUB,    16'h8000, 16'h0001, 16'h8000, 1'b0,  3'b101};

        bp[0]  = '{OP_ADD,    16'h0001, 16'h0001, 16'h0002, 1'b0,  3'b000};
        bp[1]  = '{OP_SUB,    16'h0000, 16'h0001, 16'hFFFF, 1'b0,  3'b100};
        bp[2]  = '{OP_XOR,    16'h0F0F, 16'h0F0F, 16'h0000, 1'b0,  3'b110};
        bp[3]  = '{OP_ADD,    16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0,  3'b001};

        // Reset state
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = 4'h0;
        alu_in1   = '0;
        alu_in2   = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_alu_out", 32'(alu_out), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_flags", 32'({n_flag, z_flag, v_flag}), 32'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Single-op table
        prev = 3'b000;
        for (int i = 0; i < 24; i++) begin
            run_vec(i, prev);
            prev = vt[i].nzv;
        end

        // Back-pressure: four ops, consumer stalled for three cycles
        in_i      = 0;
        out_i     = 0;
        acc_pend  = 1'b0;
        flg_pend  = 1'b0;
        cur_flags = prev;
        @(negedge clk);
        out_ready = 1'b0;
        drive(bp[0]);
        in_valid = 1'b1;
        #1;
        for (int c = 0; c < 40 && out_i < 4; c++) begin
            if (in_valid && in_ready) acc_pend = 1'b1;
            if (c == 2)
                chk("bp_accepted_before_stall", 32'(in_i), 32'd2);
            if (c >= 2 && c <= 4) begin
                chk($sformatf("bp_c%0d_in_ready", c), 32'(in_ready), 32'd0);
                chk($sformatf("bp_c%0d_out_valid", c), 32'(out_valid), 32'd1);
                chk($sformatf("bp_c%0d_hold_out", c), 32'(alu_out), 32'(bp[0].out));
                chk($sformatf("bp_c%0d_flags_hold", c), 32'({n_flag, z_flag, v_flag}), 32'(cur_flags));
            end
            if (out_valid && out_ready) begin
                chk($sformatf("bp_out%0d", out_i), 32'(alu_out), 32'(bp[out_i].out));
                chk($sformatf("bp_err%0d", out_i), 32'(error), 32'(bp[out_i].err));
                cur_flags = bp[out_i].nzv;
                out_i++;
                flg_pend = 1'b1;
            end
            @(negedge clk);
            if (flg_pend) begin
                chk($sformatf("bp_flags%0d", out_i - 1), 32'({n_flag, z_flag, v_flag}), 32'(cur_flags));
                flg_pend = 1'b0;
            end
            if (acc_pend) begin
                in_i++;
                if (in_i < 4) drive(bp[in_i]);
                else          in_valid = 1'b0;
                acc_pend = 1'b0;
            end
            out_ready = (c >= 4);
            #1;
        end
        in_valid = 1'b0;
        chk("bp_results_drained", 32'(out_i), 32'd4);
        chk("bp_all_accepted", 32'(in_i), 32'd4);

        // Reset with both stages full
        @(negedge clk);
        out_ready = 1'b0;
        drive(bp[0]);
        in_valid = 1'b1;
        @(negedge clk);
        drive(bp[1]);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("rf_in_ready_full", 32'(in_ready), 32'd0);
        chk("rf_out_valid_full", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rf_out_valid", 32'(out_valid), 32'd0);
        chk("rf_alu_out", 32'(alu_out), 32'd0);
        chk("rf_error", 32'(error), 32'd0);
        chk("rf_flags", 32'({n_flag, z_flag, v_flag}), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rf_in_ready_release", 32'(in_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rf_no_stale%0d", k), 32'(out_valid), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
